dram_input_loader: RTL and testbench

//  Upstream stage of the inference path. On start, it burst-reads one input image (num_words values) from SDRAM

---
 rtl/dram_input_loader_if.sv | 31 +++
 rtl/dram_input_loader.sv | 143 ++++++++++++++
 tb/tb_dram_input_loader.sv | 566 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_input_loader_if.sv
// Avalon-MM read master bundle for the DRAM input loader.
// master: drives address/read/write/writedata; slave: drives waitrequest/readdata/readdatavalid.
interface dram_input_loader_if;
  logic        master_waitrequest;
  logic [31:0] master_address;
  logic        master_read;
  logic [31:0] master_readdata;
  logic        master_readdatavalid;
  logic        master_write;
  logic [31:0] master_writedata;

  modport master (
    input  master_waitrequest,
    input  master_readdata,
    input  master_readdatavalid,
    output master_address,
    output master_read,
    output master_write,
    output master_writedata
  );

  modport slave (
    output master_waitrequest,
    output master_readdata,
    output master_readdatavalid,
    input  master_address,
    input  master_read,
    input  master_write,
    input  master_writedata
  );
endinterface

// File: rtl/dram_input_loader.sv
// Copies num_words values from DRAM (Avalon burst of pipelined reads) into input SRAM 0..n-1.
// Ports: clk/reset, start/num_words/mem_baddr in, done/busy out, av (Avalon master), mem_* SRAM write.
module dram_input_loader #(
  parameter int ADDR_WIDTH      = 10,
  parameter int WORD_SIZE       = 16,
  parameter int CNT_WIDTH       = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  num_words,
  input  logic [31:0]           mem_baddr,
  output logic                  done,
  output logic                  busy,
  dram_input_loader_if.master   av,
  output logic                  mem_write,
  output logic [WORD_SIZE-1:0]  mem_writedata,
  output logic [ADDR_WIDTH-1:0] mem_address
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [CNT_WIDTH-1:0] MAXO =
    CNT_WIDTH'(MAX_OUTSTANDING);

  state_t                r_state;
  logic [31:0]           r_base;
  logic [CNT_WIDTH-1:0]  r_num;
  logic [CNT_WIDTH-1:0]  r_issued;
  logic [CNT_WIDTH-1:0]  r_returned;
  logic [CNT_WIDTH-1:0]  r_out;
  logic                  r_read;
  logic [31:0]           r_addr;
  logic                  r_done;
  logic                  r_busy;
  logic                  r_mw;
  logic [WORD_SIZE-1:0]  r_mdata;
  logic [ADDR_WIDTH-1:0] r_maddr;

  logic                  w_acc;
  logic                  w_ret;
  logic [CNT_WIDTH-1:0]  w_issued_n;
  logic [CNT_WIDTH-1:0]  w_out_n;
  logic                  w_unused;

  assign w_acc = r_read && !av.master_waitrequest;

  // Responses only count while copying and when one is owed.
  assign w_ret = (r_state == S_RUN) &&
                 av.master_readdatavalid &&
                 (r_out != '0);

  assign w_issued_n = r_issued + CNT_WIDTH'(w_acc);
  assign w_out_n    = r_out + CNT_WIDTH'(w_acc)
                            - CNT_WIDTH'(w_ret);

  assign w_unused = ^av.master_readdata[31:WORD_SIZE];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_base     <= '0;
      r_num      <= '0;
      r_issued   <= '0;
      r_returned <= '0;
      r_out      <= '0;
      r_read     <= 1'b0;
      r_addr     <= '0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_mw       <= 1'b0;
      r_mdata    <= '0;
      r_maddr    <= '0;
    end else begin
      r_mw   <= 1'b0;
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_base     <= mem_baddr;
            r_num      <= num_words;
            r_issued   <= '0;
            r_returned <= '0;
            r_out      <= '0;
            r_busy     <= 1'b1;
            r_addr     <= mem_baddr << 2;
            if (num_words == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_read  <= 1'b0;
            end else begin
              r_state <= S_RUN;
              r_read  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          r_issued <= w_issued_n;
          r_out    <= w_out_n;
          if (w_ret) begin
            r_mw       <= 1'b1;
            r_mdata    <= av.master_readdata[WORD_SIZE-1:0];
            r_maddr    <= r_returned[ADDR_WIDTH-1:0];
            r_returned <= r_returned + 1'b1;
          end
          // A stalled request keeps address and read frozen.
          if (!(r_read && av.master_waitrequest)) begin
            r_read <= (w_issued_n < r_num) &&
                      (w_out_n < MAXO);
            r_addr <= (r_base + 32'(w_issued_n)) << 2;
          end
          if (r_returned == r_num) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_read  <= 1'b0;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign av.master_address   = r_addr;
  assign av.master_read      = r_read;
  assign av.master_write     = 1'b0;
  assign av.master_writedata = '0;

  assign done          = r_done;
  assign busy          = r_busy;
  assign mem_write     = r_mw;
  assign mem_writedata = r_mdata;
  assign mem_address   = r_maddr;

endmodule

// File: tb/tb_dram_input_loader.sv
// Bench for dram_input_loader: Avalon slave model with latency/stall control,
// SRAM write scoreboard and per-scenario checks.
module tb_dram_input_loader;

  localparam int AW = 10;
  localparam int WS = 16;
  localparam int CW = 16;
  localparam int MO = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] num_words = '0;
  logic [31:0]   mem_baddr = '0;
  logic          done;
  logic          busy;
  logic          mem_write;
  logic [WS-1:0] mem_writedata;
  logic [AW-1:0] mem_address;

  dram_input_loader_if av();

  dram_input_loader #(
    .ADDR_WIDTH(AW),
    .WORD_SIZE(WS),
    .CNT_WIDTH(CW),
    .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .num_words(num_words),
    .mem_baddr(mem_baddr),
    .done(done),
    .busy(busy),
    .av(av),
    .mem_write(mem_write),
    .mem_writedata(mem_writedata),
    .mem_address(mem_address)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int chks = 0;
  int cyc = 0;
  logic [31:0] seed;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] dram_val(input logic [31:0] w);
    return (w * 32'h9E37_79B1) ^ {w[15:0], w[31:16]} ^ seed;
  endfunction

  // slave configuration (written by the test sequence only)
  int lat = 1;
  int smode = 0;
  int inj_req = 0;

  // slave state and statistics (written by the slave only)
  logic [31:0] q_addr[$];
  int          q_due[$];
  logic [31:0] acc_addrs[$];
  int          inj_done = 0;
  int          stall_left = 0;
  int          stalled_at = -1;
  int          acc_cnt = 0;
  int          viol_hold = 0;
  int          viol_inflight = 0;
  int          viol_full = 0;
  int          full_cnt = 0;
  int          stall_cnt = 0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;

  always @(negedge clk) begin
    logic w;
    if (reset) begin
      q_addr.delete();
      q_due.delete();
      stall_left = 0;
      prev_stall = 1'b0;
      av.master_waitrequest   = 1'b0;
      av.master_readdatavalid = 1'b0;
      av.master_readdata      = '0;
    end else begin
      if (prev_stall &&
          (av.master_read !== 1'b1 ||
           av.master_address !== prev_addr))
        viol_hold++;
      if (q_addr.size() == MO) begin
        full_cnt++;
        if (av.master_read) viol_full++;
      end
      if (q_due.size() != 0 && q_due[0] <= cyc) begin
        av.master_readdatavalid = 1'b1;
        av.master_readdata = dram_val(q_addr[0] >> 2);
        void'(q_addr.pop_front());
        void'(q_due.pop_front());
      end else if (inj_done < inj_req) begin
        av.master_readdatavalid = 1'b1;
        av.master_readdata = $urandom;
        inj_done++;
      end else begin
        av.master_readdatavalid = 1'b0;
        av.master_readdata = $urandom;
      end
      w = 1'b0;
      if (smode == 1 && av.master_read) begin
        if (stall_left == 0 && acc_cnt % 5 == 4 &&
            stalled_at != acc_cnt) begin
          stall_left = 3;
          stalled_at = acc_cnt;
          stall_cnt++;
        end
        if (stall_left > 0) begin
          w = 1'b1;
          stall_left--;
        end
      end else if (smode == 2) begin
        w = ($urandom_range(0, 3) == 0);
      end
      av.master_waitrequest = w;
      if (av.master_read && !w) begin
        q_addr.push_back(av.master_address);
        q_due.push_back(cyc + lat);
        acc_addrs.push_back(av.master_address);
        acc_cnt++;
        if (q_addr.size() > MO) viol_inflight++;
      end
      prev_stall = av.master_read && w;
      prev_addr  = av.master_address;
    end
  end

  // SRAM write / done monitor
  logic [AW-1:0] wr_a[$];
  logic [WS-1:0] wr_d[$];
  int done_cnt = 0;
  int rd_cyc = 0;

  always @(negedge clk) begin
    if (mem_write) begin
      wr_a.push_back(mem_address);
      wr_d.push_back(mem_writedata);
    end
    if (done) done_cnt++;
    if (av.master_read) rd_cyc++;
  end

  task automatic start_copy(input int n, input logic [31:0] b,
                            output int s, output logic bz,
                            output logic d1);
    @(negedge clk);
    start = 1'b1;
    num_words = CW'(n);
    mem_baddr = b;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
    num_words = CW'($urandom);
    mem_baddr = $urandom;
    bz = busy;
    d1 = done;
  endtask

  task automatic wait_done(input int lim, output int dc, output bit ok);
    int i;
    ok = 1'b0;
    dc = 0;
    i = 0;
    while (!ok && i < lim) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        dc = cyc;
      end
      i++;
    end
  endtask

  task automatic score(input int w0, input int n,
                       input logic [31:0] b, output int bad);
    logic [31:0] v;
    bad = 0;
    if (wr_a.size() - w0 != n) bad++;
    for (int i = 0; i < n && w0 + i < wr_a.size(); i++) begin
      v = dram_val((b + 32'(i)) & 32'h3FFF_FFFF);
      if (wr_a[w0+i] !== AW'(i) || wr_d[w0+i] !== v[WS-1:0])
        bad++;
    end
  endtask

  task automatic order(input int a0, input int n,
                       input logic [31:0] b, output int bad);
    logic [31:0] e;
    bad = 0;
    if (acc_addrs.size() - a0 != n) bad++;
    for (int i = 0; i < n && a0 + i < acc_addrs.size(); i++) begin
      e = (b + 32'(i)) << 2;
      if (acc_addrs[a0+i] !== e) bad++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    num_words = 16'd5;
    repeat (3) @(negedge clk);
    chks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL reset_status: done=%b busy=%b required 0 0", done, busy);
    end
    chks++;
    if (av.master_read !== 1'b0 || av.master_address !== 32'd0) begin
      errs++;
      $display("FAIL reset_bus: read=%b addr=%h required 0 0",
               av.master_read, av.master_address);
    end
    chks++;
    if (mem_write !== 1'b0 || mem_address !== '0 || mem_writedata !== '0) begin
      errs++;
      $display("FAIL reset_sram: we=%b a=%h d=%h required 0 0 0",
               mem_write, mem_address, mem_writedata);
    end
    chks++;
    if (av.master_write !== 1'b0 || av.master_writedata !== 32'd0) begin
      errs++;
      $display("FAIL reset_write: w=%b wd=%h required 0 0",
               av.master_write, av.master_writedata);
    end
    start = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chks++;
    if (busy !== 1'b0 || av.master_read !== 1'b0) begin
      errs++;
      $display("FAIL reset_release: busy=%b read=%b required 0 0",
               busy, av.master_read);
    end
  endtask

  task automatic test_basic();
    int s, dc, w0, a0, d0, bad;
    logic bz, d1;
    bit ok;
    lat = 1;
    smode = 0;
    w0 = wr_a.size();
    a0 = acc_addrs.size();
    d0 = done_cnt;
    start_copy(786, 32'd0, s, bz, d1);
    chks++;
    if (bz !== 1'b1) begin
      errs++;
      $display("FAIL basic_busy: busy=%b required 1", bz);
    end
    wait_done(5000, dc, ok);
    chks++;
    if (!ok) begin
      errs++;
      $display("FAIL basic_timeout: done=0 required 1");
    end
    chks++;
    if (dc - s != 786 + 3) begin
      errs++;
      $display("FAIL basic_latency: cycles=%0d required %0d", dc - s, 789);
    end
    repeat (3) @(negedge clk);
    score(w0, 786, 32'd0, bad);
    chks++;
    if (bad !== 0) begin
      errs++;
      $display("FAIL basic_data: bad=%0d required 0", bad);
    end
    order(a0, 786, 32'd0, bad);
    chks++;
    if (bad !== 0) begin
      errs++;
      $display("FAIL basic_addr: bad=%0d required 0", bad);
    end
    chks++;
    if (done_cnt - d0 != 1 || busy !== 1'b0) begin
      errs++;
      $display("FAIL basic_done: pulses=%0d busy=%b required 1 0",
               done_cnt - d0, busy);
    end
  endtask

  task automatic test_stall();
    int s, dc, w0, a0, d0, h0, st0, bad;
    logic bz, d1;
    bit ok;
    lat = 1;
    smode = 1;
    w0 = wr_a.size();
    a0 = acc_addrs.size();
    d0 = done_cnt;
    h0 = viol_hold;
    st0 = stall_cnt;
    start_copy(786, 32'd7860, s, bz, d1);
    wait_done(8000, dc, ok);
    chks++;
    if (!ok) begin
      errs++;
      $display("FAIL stall_timeout: done=0 required 1");
    end
    repeat (3) @(negedge clk);
    score(w0, 786, 32'd7860, bad);
    chks++;
    if (bad !== 0) begin
      errs++;
      $display("FAIL stall_data: bad=%0d required 0", bad);
    end
    order(a0, 786, 32'd7860, bad);
    chks++;
    if (bad !== 0) begin
      errs++;
      $display("FAIL stall_addr: bad=%0d required 0", bad);
    end
    chks++;
    if (viol_hold - h0 != 0 || stall_cnt - st0 < 100) begin
      errs++;
      $display("FAIL stall_hold: unstable=%0d stalls=%0d required 0 >=100",
               viol_hold - h0, stall_cnt - st0);
    end
    chks++;
    if (done_cnt - d0 != 1) begin
      errs++;
      $display("FAIL stall_done: pulses=%0d required 1", done_cnt - d0);
    end
    smode = 0;
  endtask

  task automatic test_latency();
    int s, dc, w0, f0, v0, fc0, bad;
    logic bz, d1;
    logic [31:0] b;
    bit ok;
    lat = 6;
    smode = 0;
    b = $urandom_range(0, 1 << 20);
    w0 = wr_a.size();
    f0 = viol_full;
    v0 = viol_inflight;
    fc0 = full_cnt;
    start_copy(300, b, s, bz, d1);
    wait_done(5000, dc, ok);
    chks++;
    if (!ok) begin
      errs++;
      $display("FAIL lat_timeout: done=0 required 1");
    end
    repeat (3) @(negedge clk);
    score(w0, 300, b, bad);
    chks++;
    if (bad !== 0) begin
      errs++;
      $display("FAIL lat_data: bad=%0d required 0", bad);
    end
    chks++;
    if (viol_inflight - v0 != 0 || viol_full - f0 != 0) begin
      errs++;
      $display("FAIL lat_inflight: over=%0d read_when_full=%0d required 0 0",
               viol_inflight - v0, viol_full - f0);
    end
    chks++;
    if (full_cnt - fc0 == 0) begin
      errs++;
      $display("FAIL lat_fill: full_cycles=0 required >0");
    end
    lat = 1;
  endtask

  task automatic test_zero();
    int s, w0, a0, d0, r0;
    logic bz, d1;
    lat = 1;
    smode = 0;
    w0 = wr_a.size();
    a0 = acc_addrs.size();
    d0 = done_cnt;
    r0 = rd_cyc;
    start_copy(0, $urandom, s, bz, d1);
    chks++;
    if (d1 !== 1'b1 || bz !== 1'b1) begin
      errs++;
      $display("FAIL zero_done: done=%b busy=%b required 1 1", d1, bz);
    end
    @(negedge clk);
    chks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL zero_after: done=%b busy=%b required 0 0", done, busy);
    end
    repeat (3) @(negedge clk);
    chks++;
    if (rd_cyc != r0 || acc_addrs.size() != a0 || wr_a.size() != w0) begin
      errs++;
      $display("FAIL zero_quiet: reads=%0d writes=%0d required 0 0",
               rd_cyc - r0, wr_a.size() - w0);
    end
    chks++;
    if (done_cnt - d0 != 1) begin
      errs++;
      $display("FAIL zero_pulses: pulses=%0d required 1", done_cnt - d0);
    end
  endtask

  task automatic test_reset_abort();
    int s, dc, w0, a0, d0, n, bad;
    logic bz, d1;
    logic [31:0] b;
    bit ok;
    lat = 2;
    smode = 2;
    b = $urandom_range(0, 1 << 20);
    a0 = acc_addrs.size();
    d0 = done_cnt;
    start_copy(786, b, s, bz, d1);
    n = 0;
    while (acc_addrs.size() - a0 < 100 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chks++;
    if (acc_addrs.size() - a0 < 100) begin
      errs++;
      $display("FAIL abort_progress: accepted=%0d required >=100",
               acc_addrs.size() - a0);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    w0 = wr_a.size();
    inj_req = inj_req + 2;
    repeat (8) @(negedge clk);
    chks++;
    if (wr_a.size() != w0) begin
      errs++;
      $display("FAIL abort_late: writes=%0d required 0", wr_a.size() - w0);
    end
    chks++;
    if (busy !== 1'b0 || av.master_read !== 1'b0 || done_cnt != d0) begin
      errs++;
      $display("FAIL abort_idle: busy=%b read=%b pulses=%0d required 0 0 0",
               busy, av.master_read, done_cnt - d0);
    end
    lat = 1;
    smode = 0;
    n = $urandom_range(1, 120);
    b = $urandom;
    w0 = wr_a.size();
    d0 = done_cnt;
    start_copy(n, b, s, bz, d1);
    wait_done(2000, dc, ok);
    repeat (3) @(negedge clk);
    score(w0, n, b, bad);
    chks++;
    if (!ok || bad !== 0 || done_cnt - d0 != 1) begin
      errs++;
      $display("FAIL abort_recopy: ok=%0d bad=%0d pulses=%0d required 1 0 1",
               ok, bad, done_cnt - d0);
    end
  endtask

  task automatic test_start_held();
    int s, dc, w0, a0, d0, bad;
    logic [31:0] b;
    bit ok;
    lat = 1;
    smode = 0;
    w0 = wr_a.size();
    inj_req = inj_req + 1;
    repeat (4) @(negedge clk);
    chks++;
    if (wr_a.size() != w0) begin
      errs++;
      $display("FAIL held_spurious: writes=%0d required 0", wr_a.size() - w0);
    end
    b = $urandom_range(0, 1 << 24);
    a0 = acc_addrs.size();
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    num_words = 16'd200;
    mem_baddr = b;
    s = cyc;
    repeat (40) @(negedge clk);
    start = 1'b0;
    wait_done(2000, dc, ok);
    repeat (20) @(negedge clk);
    chks++;
    if (!ok || done_cnt - d0 != 1) begin
      errs++;
      $display("FAIL held_done: ok=%0d pulses=%0d required 1 1",
               ok, done_cnt - d0);
    end
    score(w0, 200, b, bad);
    chks++;
    if (bad !== 0) begin
      errs++;
      $display("FAIL held_data: bad=%0d required 0", bad);
    end
    order(a0, 200, b, bad);
    chks++;
    if (bad !== 0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL held_single: bad=%0d busy=%b required 0 0", bad, busy);
    end
  endtask

  task automatic test_random();
    int s, dc, w0, a0, d0, v0, n, bad, bad2;
    logic bz, d1;
    logic [31:0] b;
    bit ok;
    for (int it = 0; it < 3; it++) begin
      n = $urandom_range(1, 400);
      b = (it == 0) ? 32'hFFFF_FFF0 : $urandom;
      lat = $urandom_range(1, 6);
      smode = 2;
      w0 = wr_a.size();
      a0 = acc_addrs.size();
      d0 = done_cnt;
      v0 = viol_inflight + viol_hold;
      start_copy(n, b, s, bz, d1);
      wait_done(8000, dc, ok);
      repeat (3) @(negedge clk);
      score(w0, n, b, bad);
      order(a0, n, b, bad2);
      chks++;
      if (!ok || bad !== 0 || bad2 !== 0) begin
        errs++;
        $display("FAIL rand_copy%0d: ok=%0d data_bad=%0d addr_bad=%0d required 1 0 0",
                 it, ok, bad, bad2);
      end
      chks++;
      if (done_cnt - d0 != 1 || viol_inflight + viol_hold - v0 != 0) begin
        errs++;
        $display("FAIL rand_proto%0d: pulses=%0d violations=%0d required 1 0",
                 it, done_cnt - d0, viol_inflight + viol_hold - v0);
      end
    end
    smode = 0;
    lat = 1;
  endtask

  initial begin
    seed = $urandom;
    test_reset();
    test_basic();
    test_stall();
    test_latency();
    test_zero();
    test_reset_abort();
    test_start_held();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
